// File: rtl/addsub_op_sequencer.sv
// Sequencer around a combinational add/subtract stage: registers a request onto the
// stage inputs, waits SETTLE cycles, captures the result and presents it downstream.
module addsub_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [WIDTH-1:0] as_A,
    output logic [WIDTH-1:0] as_B,
    output logic             as_ci,
    input  logic [WIDTH-1:0] as_s,
    input  logic             as_cout,
    input  logic             as_V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_V,
    output logic             out_sub,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int CTR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(SETTLE - 1);
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] OVF_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] OVF_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   as_a_q, as_a_d;
    logic [WIDTH-1:0]   as_b_q, as_b_d;
    logic               as_ci_q, as_ci_d;
    logic [WIDTH-1:0]   out_s_q, out_s_d;
    logic               out_cout_q, out_cout_d;
    logic               out_v_q, out_v_d;
    logic               out_sub_q, out_sub_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;
    logic               in_ready_s;
    logic               accept_s;

    // Saturating increment of the overflow counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == OVF_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + OVF_ONE;
        end
    endfunction

    // Accept is possible when idle, or when the held result leaves in this same cycle.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        as_a_d      = as_a_q;
        as_b_d      = as_b_q;
        as_ci_d     = as_ci_q;
        out_s_d     = out_s_q;
        out_cout_d  = out_cout_q;
        out_v_d     = out_v_q;
        out_sub_d   = out_sub_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    as_a_d  = in_a;
                    as_b_d  = in_b;
                    as_ci_d = in_sub;
                    cnt_d   = CTR_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CTR_ZERO) begin
                    out_s_d     = as_s;
                    out_cout_d  = as_cout;
                    out_v_d     = as_V;
                    out_sub_d   = as_ci_q;
                    out_valid_d = 1'b1;
                    if (as_V) begin
                        ovf_d = sat_inc(ovf_q);
                    end else begin
                        ovf_d = ovf_q;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CTR_ONE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Back-to-back: a request arriving with the handshake starts immediately.
                    if (accept_s) begin
                        as_a_d  = in_a;
                        as_b_d  = in_b;
                        as_ci_d = in_sub;
                        cnt_d   = CTR_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CTR_ZERO;
            as_a_q      <= {WIDTH{1'b0}};
            as_b_q      <= {WIDTH{1'b0}};
            as_ci_q     <= 1'b0;
            out_s_q     <= {WIDTH{1'b0}};
            out_cout_q  <= 1'b0;
            out_v_q     <= 1'b0;
            out_sub_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            as_a_q      <= as_a_d;
            as_b_q      <= as_b_d;
            as_ci_q     <= as_ci_d;
            out_s_q     <= out_s_d;
            out_cout_q  <= out_cout_d;
            out_v_q     <= out_v_d;
            out_sub_q   <= out_sub_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign as_A      = as_a_q;
    assign as_B      = as_b_q;
    assign as_ci     = as_ci_q;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_cout  = out_cout_q;
    assign out_V     = out_v_q;
    assign out_sub   = out_sub_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Self-checking bench for addsub_op_sequencer: directed table, corner sequences and a
// randomized run against a transaction-level model; the 4-bit Add_Sub stage is modelled here.
module tb_addsub_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Add_Sub behaviour from plain arithmetic: {cout, V, s}
    function automatic logic [5:0] addsub_f(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int ua, ub, sa, sb, sum, ss;
        logic [5:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        if (ci) begin
            sum = ua + 16 - ub;
            ss  = sa - sb;
        end else begin
            sum = ua + ub;
            ss  = sa + sb;
        end
        r[5]   = (sum >= 16) ? 1'b1 : 1'b0;
        r[4]   = (ss < -8 || ss > 7) ? 1'b1 : 1'b0;
        r[3:0] = sum[3:0];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- DUT 1: SETTLE=1, CNT_W=8 ----------------
    logic       iv, ir, isub, ord, ov, oco, oV, osub, ci1, co1, v1;
    logic [3:0] ia, ib, A1, B1, s1, os;
    logic [7:0] ovf1;
    assign {co1, v1, s1} = addsub_f(A1, B1, ci1);

    addsub_op_sequencer #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_sub(isub),
        .as_A(A1), .as_B(B1), .as_ci(ci1), .as_s(s1), .as_cout(co1), .as_V(v1),
        .out_valid(ov), .out_ready(ord), .out_s(os), .out_cout(oco), .out_V(oV), .out_sub(osub),
        .ovf_count(ovf1));

    // ---------------- DUT 3: SETTLE=3 ----------------
    logic       iv3, ir3, isub3, ord3, ov3, oco3, oV3, osub3, ci3, co3, v3;
    logic [3:0] ia3, ib3, A3, B3, s3, os3;
    logic [7:0] ovf3;
    assign {co3, v3, s3} = addsub_f(A3, B3, ci3);

    addsub_op_sequencer #(.WIDTH(4), .SETTLE(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_a(ia3), .in_b(ib3), .in_sub(isub3),
        .as_A(A3), .as_B(B3), .as_ci(ci3), .as_s(s3), .as_cout(co3), .as_V(v3),
        .out_valid(ov3), .out_ready(ord3), .out_s(os3), .out_cout(oco3), .out_V(oV3), .out_sub(osub3),
        .ovf_count(ovf3));

    // ---------------- DUT C: CNT_W=2 ----------------
    logic       ivc, irc, isubc, ordc, ovc, ococ, oVc, osubc, cic, coc, vc;
    logic [3:0] iac, ibc, Ac, Bc, sc, osc;
    logic [1:0] ovfc;
    assign {coc, vc, sc} = addsub_f(Ac, Bc, cic);

    addsub_op_sequencer #(.WIDTH(4), .SETTLE(1), .CNT_W(2)) dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(ivc), .in_ready(irc), .in_a(iac), .in_b(ibc), .in_sub(isubc),
        .as_A(Ac), .as_B(Bc), .as_ci(cic), .as_s(sc), .as_cout(coc), .as_V(vc),
        .out_valid(ovc), .out_ready(ordc), .out_s(osc), .out_cout(ococ), .out_V(oVc), .out_sub(osubc),
        .ovf_count(ovfc));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] s;
        logic       cout;
        logic       v;
    } vec_t;

    vec_t tbl[8];
    int   exp_ovf;

    // Full transaction on DUT 1 from idle: accept, measure latency, check, handshake.
    task automatic run_op1(input string name, input logic [3:0] a, input logic [3:0] b, input logic sub,
                           input logic [3:0] es, input logic eco, input logic ev);
        int lat;
        @(negedge clk);
        iv = 1'b1; ia = a; ib = b; isub = sub; ord = 1'b0;
        #1 chk({name, " in_ready"}, int'(ir), 1);
        @(posedge clk);
        #1 iv = 1'b0;
        chk({name, " as_A"}, int'(A1), int'(a));
        chk({name, " as_ci"}, int'(ci1), int'(sub));
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov) break;
        end
        chk({name, " latency"}, lat, 1);
        chk({name, " s"}, int'(os), int'(es));
        chk({name, " cout"}, int'(oco), int'(eco));
        chk({name, " V"}, int'(oV), int'(ev));
        chk({name, " out_sub"}, int'(osub), int'(sub));
        if (ev) exp_ovf++;
        chk({name, " ovf_count"}, int'(ovf1), exp_ovf);
        ord = 1'b1;
        @(posedge clk);
        #1 ord = 1'b0;
        chk({name, " out_valid drop"}, int'(ov), 0);
    endtask

    // Random-run model state: one outstanding transaction at most.
    bit         m_pend;
    int         m_rem;
    logic [3:0] m_a, m_b, m_sh_s;
    logic       m_sub, m_sh_co, m_sh_v, m_sh_sub;

    initial begin
        logic [5:0] r;
        bit exp_ov, exp_ir, hs, acc;
        int lat;
        int seq_c[5];
        logic [3:0] ca[5], cb[5];
        logic       cs[5];

        tbl[0] = '{4'd7,  4'd14, 1'b0, 4'd5,  1'b1, 1'b0};
        tbl[1] = '{4'd6,  4'd5,  1'b0, 4'd11, 1'b0, 1'b1};
        tbl[2] = '{4'd2,  4'd8,  1'b1, 4'd10, 1'b0, 1'b1};
        tbl[3] = '{4'd5,  4'd3,  1'b1, 4'd2,  1'b1, 1'b0};
        tbl[4] = '{4'd0,  4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
        tbl[5] = '{4'd8,  4'd1,  1'b1, 4'd7,  1'b1, 1'b1};
        tbl[6] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
        tbl[7] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};

        rst_n = 1'b0;
        iv = 1'b0; ia = 4'd0; ib = 4'd0; isub = 1'b0; ord = 1'b0;
        iv3 = 1'b0; ia3 = 4'd0; ib3 = 4'd0; isub3 = 1'b0; ord3 = 1'b0;
        ivc = 1'b0; iac = 4'd0; ibc = 4'd0; isubc = 1'b0; ordc = 1'b1;
        exp_ovf = 0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(ov), 0);
        chk("reset in_ready", int'(ir), 1);
        chk("reset ovf_count", int'(ovf1), 0);
        chk("reset as_A", int'(A1), 0);
        chk("reset out_s", int'(os), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op1($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].cout, tbl[i].v);
        end

        // Asynchronous reset in the middle of SETTLE drops the transaction.
        @(negedge clk);
        iv = 1'b1; ia = 4'd6; ib = 4'd5; isub = 1'b0;
        @(posedge clk);
        #1 iv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid out_valid", int'(ov), 0);
        chk("rst mid in_ready", int'(ir), 1);
        chk("rst mid ovf_count", int'(ovf1), 0);
        chk("rst mid as_A", int'(A1), 0);
        chk("rst mid as_B", int'(B1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ovf = 0;
        repeat (2) @(negedge clk);
        chk("rst no result", int'(ov), 0);

        // Backpressure: held result stays put, new requests are refused.
        @(negedge clk);
        iv = 1'b1; ia = 4'd3; ib = 4'd4; isub = 1'b0; ord = 1'b0;
        @(posedge clk);
        #1 iv = 1'b0;
        @(posedge clk);
        #1 chk("bp first valid", int'(ov), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv = 1'b1; ia = 4'($urandom); ib = 4'($urandom); isub = 1'($urandom);
            #1 chk("bp in_ready", int'(ir), 0);
            @(posedge clk);
            #1;
            chk("bp out_s", int'(os), 7);
            chk("bp out_valid", int'(ov), 1);
            chk("bp as_A", int'(A1), 3);
        end
        @(negedge clk);
        iv = 1'b1; ia = 4'd9; ib = 4'd9; isub = 1'b0; ord = 1'b1;
        #1 chk("bp release in_ready", int'(ir), 1);
        @(posedge clk);
        #1 iv = 1'b0; ord = 1'b0;
        chk("bp gap out_valid", int'(ov), 0);
        chk("bp new as_A", int'(A1), 9);
        @(posedge clk);
        #1;
        chk("bp new out_valid", int'(ov), 1);
        chk("bp new s", int'(os), 2);
        chk("bp new cout", int'(oco), 1);
        chk("bp new V", int'(oV), 1);
        exp_ovf = 1;
        chk("bp ovf_count", int'(ovf1), exp_ovf);
        ord = 1'b1;
        @(posedge clk);
        #1 ord = 1'b0;

        // Randomized run against the transaction model.
        m_pend = 1'b0; m_rem = 0;
        m_sh_s = 4'd2; m_sh_co = 1'b1; m_sh_v = 1'b1; m_sh_sub = 1'b0;
        m_a = 4'd0; m_b = 4'd0; m_sub = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            iv = 1'($urandom); ia = 4'($urandom); ib = 4'($urandom); isub = 1'($urandom);
            ord = ($urandom_range(0, 3) != 0);
            #1;
            exp_ov = m_pend && (m_rem == 0);
            exp_ir = !m_pend || (exp_ov && ord);
            chk("rnd in_ready", int'(ir), int'(exp_ir));
            chk("rnd out_valid", int'(ov), int'(exp_ov));
            chk("rnd ovf_count", int'(ovf1), exp_ovf);
            if (exp_ov) begin
                chk("rnd s", int'(os), int'(m_sh_s));
                chk("rnd cout", int'(oco), int'(m_sh_co));
                chk("rnd V", int'(oV), int'(m_sh_v));
                chk("rnd out_sub", int'(osub), int'(m_sh_sub));
            end
            if (m_pend) chk("rnd as_A", int'(A1), int'(m_a));
            hs  = exp_ov && ord;
            acc = iv && exp_ir;
            if (m_pend && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    r = addsub_f(m_a, m_b, m_sub);
                    m_sh_s = r[3:0]; m_sh_v = r[4]; m_sh_co = r[5]; m_sh_sub = m_sub;
                    if (r[4] && exp_ovf < 255) exp_ovf++;
                end
            end
            if (hs) m_pend = 1'b0;
            if (acc) begin
                m_pend = 1'b1; m_rem = 1; m_a = ia; m_b = ib; m_sub = isub;
            end
            @(posedge clk);
        end
        @(negedge clk);
        iv = 1'b0; ord = 1'b1;

        // SETTLE=3 latency.
        @(negedge clk);
        iv3 = 1'b1; ia3 = 4'd5; ib3 = 4'd3; isub3 = 1'b1;
        @(posedge clk);
        #1 iv3 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov3) break;
        end
        chk("s3 latency", lat, 3);
        chk("s3 s", int'(os3), 2);
        chk("s3 cout", int'(oco3), 1);
        chk("s3 V", int'(oV3), 0);
        chk("s3 out_sub", int'(osub3), 1);

        // Saturation with a 2-bit counter.
        ca = '{4'd6, 4'd7, 4'd2, 4'd8, 4'd9};
        cb = '{4'd5, 4'd1, 4'd8, 4'd1, 4'd9};
        cs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        seq_c = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ivc = 1'b1; iac = ca[i]; ibc = cb[i]; isubc = cs[i];
            @(posedge clk);
            #1 ivc = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d valid", i), int'(ovc), 1);
            chk($sformatf("sat%0d V", i), int'(oVc), 1);
            chk($sformatf("sat%0d ovf_count", i), int'(ovfc), seq_c[i]);
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
